// File: rtl/cache_refill.sv
// cache_refill: memory-side line refill engine for the set-associative cache.
// On a miss it reads the line as XLEN-bit words. At most MAX_OUT reads are in
// flight, and responses come back in request order. It assembles the line and
// drives a one-cycle fill strobe toward the cache.
// Optional build macro: CACHE_REFILL_CRITICAL_WORD_FIRST_EN. When it is defined,
// the word order starts at the missing word and the first response is also
// forwarded to crit_valid/crit_data.
// Handshakes: a request transfers on a rising edge where mem_req_valid and
// mem_req_ready are both high. While valid is high and ready is low, the
// request address holds. A miss transfers when miss_valid and miss_ready are
// both high. Responses need no ready; each mem_resp_valid cycle carries one word.
module cache_refill #(
   parameter int XLEN      = 32,
   parameter int LINE_SIZE = 64,
   parameter int MAX_OUT   = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     miss_valid,
   output logic                     miss_ready,
   input  logic [XLEN-1:0]          miss_addr,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [XLEN-1:0]          mem_req_addr,
   input  logic                     mem_resp_valid,
   input  logic [XLEN-1:0]          mem_resp_data,
   output logic                     fill_en,
   output logic [XLEN-1:0]          fill_addr,
   output logic [8*LINE_SIZE-1:0]   fill_data,
   output logic                     busy,
   output logic                     crit_valid,
   output logic [XLEN-1:0]          crit_data
);

   localparam int NWORDS  = 8 * LINE_SIZE / XLEN;
   localparam int NOFFSET = $clog2(LINE_SIZE);
   localparam int WB      = $clog2(XLEN / 8);
   localparam int IW      = $clog2(NWORDS);
   localparam int CW      = IW + 1;
   localparam int LW      = 8 * LINE_SIZE;
   localparam logic [CW-1:0] NWORDS_C  = CW'(NWORDS);
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FILL  = 2'd2
   } state_t;

   state_t          state;
   logic [XLEN-1:0] base;
   logic [CW-1:0]   issued;
   logic [CW-1:0]   received;
   logic [LW-1:0]   line_buf;

   logic            fire_req;
   logic            fire_resp;
   logic            req_more;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   issued_nx;
   logic [CW-1:0]   received_nx;
   logic [IW-1:0]   req_idx;
   logic [IW-1:0]   rx_idx;
   logic [IW-1:0]   first_idx;
   logic [XLEN-1:0] miss_base;
   logic [XLEN-1:0] req_off;
   logic [XLEN-1:0] first_off;
   logic [LW-1:0]   line_nx;

   // The byte offset inside the line only matters for the word order.
   logic unused_offset;
   assign unused_offset = ^miss_addr[NOFFSET-1:0];

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
   logic [IW-1:0] crit_idx;

   // Word order wraps from the missing word, so slot n maps to (c + n) mod NWORDS.
   assign first_idx = miss_addr[NOFFSET-1:WB];
   assign req_idx   = crit_idx + issued_nx[IW-1:0];
   assign rx_idx    = crit_idx + received[IW-1:0];

   // The first accepted response of a refill goes straight to the core.
   assign crit_valid = fire_resp & (received == '0);
   assign crit_data  = crit_valid ? mem_resp_data : '0;

   // Remember the critical word index for the whole refill.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         crit_idx <= '0;
      end else if (state == ST_IDLE && miss_valid) begin
         crit_idx <= miss_addr[NOFFSET-1:WB];
      end
   end
`else
   assign first_idx  = '0;
   assign req_idx    = issued_nx[IW-1:0];
   assign rx_idx     = received[IW-1:0];
   assign crit_valid = 1'b0;
   assign crit_data  = '0;
`endif

   assign miss_base   = {miss_addr[XLEN-1:NOFFSET], {NOFFSET{1'b0}}};
   assign fire_req    = mem_req_valid & mem_req_ready;
   assign outstanding = issued - received;
   // A response with nothing in flight (for example a leftover after reset) is dropped.
   assign fire_resp   = (state == ST_FETCH) & mem_resp_valid & (outstanding != '0);
   assign issued_nx   = issued + {{(CW-1){1'b0}}, fire_req};
   assign received_nx = received + {{(CW-1){1'b0}}, fire_resp};
   // The request valid for the next cycle is evaluated on that cycle's counts.
   assign req_more    = (issued_nx < NWORDS_C) && ((issued_nx - received_nx) < MAX_OUT_C);

   // Turn word indices into byte offsets within the line.
   always_comb begin
      req_off   = '0;
      first_off = '0;
      req_off[NOFFSET-1:WB]   = req_idx;
      first_off[NOFFSET-1:WB] = first_idx;
   end

   // Merge the returning word into its slot of the line being assembled.
   always_comb begin
      line_nx = line_buf;
      if (fire_resp) begin
         line_nx[int'(rx_idx) * XLEN +: XLEN] = mem_resp_data;
      end
   end

   // Refill control: accept the miss, stream the requests and responses, then strobe the fill.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         miss_ready    <= 1'b1;
         busy          <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         fill_en       <= 1'b0;
         fill_addr     <= '0;
         fill_data     <= '0;
         base          <= '0;
         issued        <= '0;
         received      <= '0;
         line_buf      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               fill_en <= 1'b0;
               if (miss_valid) begin
                  base          <= miss_base;
                  issued        <= '0;
                  received      <= '0;
                  mem_req_addr  <= miss_base + first_off;
                  mem_req_valid <= 1'b1;
                  miss_ready    <= 1'b0;
                  busy          <= 1'b1;
                  state         <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               issued   <= issued_nx;
               received <= received_nx;
               line_buf <= line_nx;
               if (received_nx == NWORDS_C) begin
                  mem_req_valid <= 1'b0;
                  fill_en       <= 1'b1;
                  fill_addr     <= base;
                  fill_data     <= line_nx;
                  state         <= ST_FILL;
               end else begin
                  mem_req_valid <= req_more;
                  if (req_more) begin
                     mem_req_addr <= base + req_off;
                  end
               end
            end
            ST_FILL: begin
               fill_en    <= 1'b0;
               miss_ready <= 1'b1;
               busy       <= 1'b0;
               issued     <= '0;
               received   <= '0;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_refill.sv
// tb_cache_refill: randomized bench for cache_refill. It uses a behavioural
// memory with in-order, variable-latency replies. Expected request addresses
// and line contents come from the line base, the word order and a
// memory-content function.
module tb_cache_refill;

   localparam int XLEN      = 32;
   localparam int LINE_SIZE = 64;
   localparam int MAX_OUT   = 2;
   localparam int NWORDS    = 8 * LINE_SIZE / XLEN;
   localparam int LW        = 8 * LINE_SIZE;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic            clock = 1'b0;
   logic            reset_n;
   logic            miss_valid;
   logic            miss_ready;
   logic [XLEN-1:0] miss_addr;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_resp_valid;
   logic [XLEN-1:0] mem_resp_data;
   logic            fill_en;
   logic [XLEN-1:0] fill_addr;
   logic [LW-1:0]   fill_data;
   logic            busy;
   logic            crit_valid;
   logic [XLEN-1:0] crit_data;

   int compared   = 0;
   int mismatched = 0;

   logic [XLEN-1:0] exp_q[$];
   int              resp_due[$];
   logic [XLEN-1:0] resp_data[$];
   logic [XLEN-1:0] salt;

   // clock and reset
   always #5 clock = ~clock;

   cache_refill #(.XLEN(XLEN), .LINE_SIZE(LINE_SIZE), .MAX_OUT(MAX_OUT)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .miss_valid     (miss_valid),
      .miss_ready     (miss_ready),
      .miss_addr      (miss_addr),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .fill_en        (fill_en),
      .fill_addr      (fill_addr),
      .fill_data      (fill_data),
      .busy           (busy),
      .crit_valid     (crit_valid),
      .crit_data      (crit_data)
   );

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // memory contents: a simple function of the byte address
   function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
      return a ^ salt;
   endfunction

   task automatic check_reset(input string pfx);
      check({pfx, "_miss_ready"}, miss_ready, 1);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_req_valid"}, mem_req_valid, 0);
      check({pfx, "_req_addr"}, mem_req_addr, 0);
      check({pfx, "_fill_en"}, fill_en, 0);
      check({pfx, "_fill_addr"}, fill_addr, 0);
      check({pfx, "_fill_data"}, fill_data, 0);
      check({pfx, "_crit_valid"}, crit_valid, 0);
      check({pfx, "_crit_data"}, crit_data, 0);
   endtask

   // driver plus memory model for one refill; called and returns at cycle start (posedge + 1)
   task automatic do_refill(input logic [XLEN-1:0] addr, input int ready_pct, input int lat_max,
                            input bit chk_lat, input bit hold_next, input logic [XLEN-1:0] next_addr,
                            input int abort_after, input bit expect_now);
      logic [XLEN-1:0] base;
      logic [XLEN-1:0] stall_addr;
      logic [LW-1:0]   exp_line;
      int c, issued, delivered, max_out, fills, acc_cyc, fill_cyc, last_due, due, lat;
      bit accepted, done, early, stall_v, first;
      base = addr & 32'hFFFF_FFC0;
      c    = CWF ? int'(addr[5:2]) : 0;
      exp_q.delete();
      resp_due.delete();
      resp_data.delete();
      for (int n = 0; n < NWORDS; n++) exp_q.push_back(base + 32'(((c + n) % NWORDS) * 4));
      for (int k = 0; k < NWORDS; k++) exp_line[k*XLEN +: XLEN] = mem_word(base + 32'(k * 4));
      issued = 0; delivered = 0; max_out = 0; fills = 0; acc_cyc = 0; fill_cyc = 0;
      last_due = -1; accepted = 0; done = 0; early = 0; stall_v = 0; stall_addr = '0;
      miss_valid = 1'b1;
      miss_addr  = addr;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (abort_after > 0 && delivered == abort_after) begin
            reset_n        = 1'b0;
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            miss_valid     = 1'b0;
            @(posedge clock); #1;
            reset_n = 1'b1;
            check_reset("abort");
            check("abort_no_fill", fills, 0);
            done = 1;
            break;
         end
         if (accepted) begin
            if (issued - delivered > max_out) max_out = issued - delivered;
            if (stall_v) begin
               check("stall_valid", mem_req_valid, 1);
               check("stall_addr", mem_req_addr, stall_addr);
            end
            if (fill_en) begin
               fills++;
               fill_cyc = cyc;
               check("fill_addr", fill_addr, base);
               check("fill_data", fill_data, exp_line);
               check("fill_words", delivered, NWORDS);
               check("req_left", exp_q.size(), 0);
               check("max_out_ok", max_out <= MAX_OUT, 1);
               check("ready_at_fill", miss_ready, 0);
               if (chk_lat) check("latency", fill_cyc - acc_cyc, NWORDS + 2);
            end else if (fills > 0) begin
               check("fill_pulses", fills, 1);
               check("ready_after_fill", miss_ready, 1);
               check("busy_after_fill", busy, 0);
               check("no_early_accept", early, 0);
               done = 1;
               break;
            end else if (miss_ready) begin
               early = 1;
            end
         end
         mem_req_ready = ($urandom_range(99) < ready_pct);
         if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = resp_data[0];
         end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
         end
         #1;
         if (!accepted && miss_valid && miss_ready) begin
            accepted = 1;
            acc_cyc  = cyc;
         end
         if (mem_resp_valid) begin
            first = (delivered == 0);
            check("crit_valid", crit_valid, CWF && first);
            if (!CWF || first) check("crit_data", crit_data, CWF ? mem_resp_data : '0);
            void'(resp_due.pop_front());
            void'(resp_data.pop_front());
            delivered++;
         end
         stall_v    = mem_req_valid && !mem_req_ready;
         stall_addr = mem_req_addr;
         if (mem_req_valid && mem_req_ready) begin
            if (exp_q.size() == 0) check("extra_req", mem_req_addr, '1);
            else check("req_addr", mem_req_addr, exp_q.pop_front());
            issued++;
            lat = int'($urandom_range(lat_max, 1));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            resp_due.push_back(due);
            resp_data.push_back(mem_word(mem_req_addr));
         end
         @(posedge clock); #1;
         if (accepted && !hold_next) miss_valid = 1'b0;
         if (accepted && hold_next) miss_addr = next_addr;
      end
      if (!done) check("timeout", 0, 1);
      if (expect_now) check("b2b_accept_cycle", acc_cyc, 0);
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
   endtask

   initial begin
      reset_n        = 1'b0;
      miss_valid     = 1'b0;
      miss_addr      = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      salt           = '0;
      repeat (3) @(posedge clock);
      #1;
      check_reset("por");
      reset_n = 1'b1;
      @(posedge clock); #1;
      check("idle_ready", miss_ready, 1);

      // basic refill, data equals address, full-rate memory
      salt = '0;
      do_refill(32'h0000_1234, 100, 1, 1, 0, '0, 0, 0);

      // backpressure with longer latency
      salt = 32'hA5A5_0F0F;
      do_refill(32'h0000_2A58, 50, 4, 0, 0, '0, 0, 0);

      // random misses, ready rates and latencies
      for (int i = 0; i < 6; i++) begin
         salt = $urandom;
         do_refill($urandom, int'($urandom_range(100, 30)), int'($urandom_range(4, 1)), 0, 0, '0, 0, 0);
      end

      // reset after five responses, then stray responses in idle
      salt = '0;
      do_refill(32'h0000_7310, 100, 1, 0, 0, '0, 5, 0);
      for (int i = 0; i < 3; i++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = $urandom;
         #1;
         check("stray_crit", crit_valid, 0);
         @(posedge clock); #1;
         check("stray_busy", busy, 0);
         check("stray_fill", fill_en, 0);
      end
      mem_resp_valid = 1'b0;
      do_refill(32'h0000_4000, 80, 2, 0, 0, '0, 0, 0);

      // back-to-back misses with miss_valid held high
      salt = '0;
      do_refill(32'h0000_1238, 100, 1, 1, 1, 32'h0000_8040, 0, 0);
      do_refill(32'h0000_8040, 100, 1, 1, 0, '0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
